// File: rtl/iterative_alu_if.sv
// ---------------------------------------------------------------------------
// iterative_alu_if
//
// Request/response bundle between the datapath control and iterative_alu.
//
// Signals
//   start         request strobe; only sampled by the ALU while it is idle
//   ALUOperation  4-bit operation code from the ALU control decoder
//   A             operand A (rs)
//   B             operand B (rt / immediate); source operand for shifts
//   shamt         shift amount (instruction[10:6])
//   busy          high whenever the ALU is not idle
//   done          one-cycle pulse marking a fresh ALUResult
//   ALUResult     registered result, held until the next completion
//   Zero          registered flag, (ALUResult == 0)
//
// Modports
//   master  datapath side: drives the request, observes the response
//   slave   ALU side: observes the request, drives the response
// ---------------------------------------------------------------------------
interface iterative_alu_if #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = 5
);
    logic                   start;
    logic [3:0]             ALUOperation;
    logic [DATA_WIDTH-1:0]  A;
    logic [DATA_WIDTH-1:0]  B;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   busy;
    logic                   done;
    logic [DATA_WIDTH-1:0]  ALUResult;
    logic                   Zero;

    modport master (
        output start,
        output ALUOperation,
        output A,
        output B,
        output shamt,
        input  busy,
        input  done,
        input  ALUResult,
        input  Zero
    );

    modport slave (
        input  start,
        input  ALUOperation,
        input  A,
        input  B,
        input  shamt,
        output busy,
        output done,
        output ALUResult,
        output Zero
    );
endinterface

// File: rtl/iterative_alu.sv
// ---------------------------------------------------------------------------
// iterative_alu
//
// Multi-cycle ALU fed by the ALU control decoder. Logical and add/sub
// operations finish in one cycle; SLL/SRL are executed bit-serially, one
// bit position per cycle, so no barrel shifter is needed. The caller issues
// a request with start and stalls on busy until done pulses.
//
// Parameters
//   DATA_WIDTH   operand and result width
//   SHAMT_WIDTH  shift-amount width; must equal log2(DATA_WIDTH)
//
// Ports
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset; aborts any operation in flight
//   bus    iterative_alu_if slave modport (request in, result out)
//
// Operation codes
//   0000 AND   0001 OR   0010 NOR   0011 ADD   0100 SUB
//   1111 SLL (B << shamt)   1110 SRL (B >> shamt, zero fill)
//   anything else yields 0
//
// Latency (start sampled at the end of cycle 0)
//   single-cycle ops, or a shift by 0 : done in cycle 1
//   shift by s > 0                    : done in cycle s+1, busy cycles 1..s+1
// ---------------------------------------------------------------------------
module iterative_alu #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = 5
) (
    input  logic         clk,
    input  logic         reset,
    iterative_alu_if.slave bus
);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpNor = 4'b0010;
    localparam logic [3:0] OpAdd = 4'b0011;
    localparam logic [3:0] OpSub = 4'b0100;
    localparam logic [3:0] OpSrl = 4'b1110;
    localparam logic [3:0] OpSll = 4'b1111;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_t;

    state_t                 state_q;
    logic                   busy_q;
    logic                   done_q;
    logic [DATA_WIDTH-1:0]  result_q;
    logic                   zero_q;

    // Shift engine: latched direction, partially shifted operand, bits left.
    logic                   shift_left_q;
    logic [DATA_WIDTH-1:0]  work_q;
    logic [SHAMT_WIDTH-1:0] cnt_q;

    // Single-cycle result, straight from the request inputs. For shift codes
    // this is only used when shamt is zero, where the answer is B itself.
    logic [DATA_WIDTH-1:0]  quick_result;
    logic                   is_shift;
    logic [DATA_WIDTH-1:0]  work_next;

    always_comb begin
        quick_result = '0;
        case (bus.ALUOperation)
            OpAnd:   quick_result = bus.A & bus.B;
            OpOr:    quick_result = bus.A | bus.B;
            OpNor:   quick_result = ~(bus.A | bus.B);
            OpAdd:   quick_result = bus.A + bus.B;
            OpSub:   quick_result = bus.A - bus.B;
            OpSll:   quick_result = bus.B;
            OpSrl:   quick_result = bus.B;
            default: quick_result = '0;
        endcase
    end

    assign is_shift = (bus.ALUOperation == OpSll) || (bus.ALUOperation == OpSrl);

    always_comb begin
        work_next = shift_left_q ? {work_q[DATA_WIDTH-2:0], 1'b0}
                                 : {1'b0, work_q[DATA_WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b1;
            shift_left_q <= 1'b0;
            work_q       <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (is_shift && (bus.shamt != '0)) begin
                            // Capture everything the shift needs; later input
                            // changes must not disturb the operation.
                            shift_left_q <= (bus.ALUOperation == OpSll);
                            work_q       <= bus.B;
                            cnt_q        <= bus.shamt;
                            state_q      <= StShift;
                        end else begin
                            result_q <= quick_result;
                            zero_q   <= (quick_result == '0);
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end
                    end
                end

                StShift: begin
                    work_q <= work_next;
                    cnt_q  <= cnt_q - SHAMT_WIDTH'(1);
                    if (cnt_q == SHAMT_WIDTH'(1)) begin
                        result_q <= work_next;
                        zero_q   <= (work_next == '0);
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end

                StDone: begin
                    // start is deliberately ignored here; no request queuing.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ALUResult = result_q;
    assign bus.Zero      = zero_q;

    // done only ever appears while busy, and never on two cycles in a row.
    a_done_busy : assert property (@(posedge clk) disable iff (!reset)
        done_q |-> busy_q);
    a_done_pulse : assert property (@(posedge clk) disable iff (!reset)
        done_q |=> !done_q);

endmodule

// File: tb/tb_iterative_alu.sv
// ---------------------------------------------------------------------------
// tb_iterative_alu
//
// Scoreboard bench for iterative_alu. The driver computes each accepted
// request's expected result and completion cycle from a reference model and
// queues it; an independent monitor checks every done pulse, the busy window
// and result stability against that queue.
// ---------------------------------------------------------------------------
module tb_iterative_alu;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 5;

    logic clk;
    logic reset;

    iterative_alu_if #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) bus ();

    iterative_alu #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] res;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   win_lo   = 1;
    int   win_hi   = 0;
    bit   mon_en   = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model straight from the operation table.
    function automatic logic [DW-1:0] ref_alu(input logic [3:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input int sh);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return ~(a | b);
            4'b0011: return a + b;
            4'b0100: return a - b;
            4'b1111: return b << sh;
            4'b1110: return b >> sh;
            default: return '0;
        endcase
    endfunction

    function automatic int latency(input logic [3:0] op, input int sh);
        if ((op == 4'b1111 || op == 4'b1110) && sh > 0) return sh + 1;
        return 1;
    endfunction

    task automatic scramble_inputs();
        bus.ALUOperation = 4'($urandom_range(0, 15));
        bus.A            = $urandom;
        bus.B            = $urandom;
        bus.shamt        = 5'($urandom_range(0, 31));
    endtask

    // Called at negedge+2; presents one request for one cycle and records it.
    task automatic issue(input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input int sh);
        exp_t e;
        int   c;
        bus.ALUOperation = op;
        bus.A            = a;
        bus.B            = b;
        bus.shamt        = 5'(sh);
        bus.start        = 1'b1;
        c      = cyc;
        e.res  = ref_alu(op, a, b, sh);
        e.cyc  = c + latency(op, sh);
        sb.push_back(e);
        win_lo = c + 1;
        win_hi = e.cyc;
        @(negedge clk); #2;
        bus.start = 1'b0;
        scramble_inputs();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            @(negedge clk); #2;
            n++;
        end
        if (n >= 100) chk("busy_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #2;
        end
    endtask

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    logic [DW-1:0] prev_res = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && mon_en) begin
                chk("busy_window", 32'(bus.busy),
                    32'((cyc >= win_lo) && (cyc <= win_hi)));
                if (bus.done === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'(bus.done), 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("result", bus.ALUResult, e.res);
                        chk("zero", 32'(bus.Zero), 32'(e.res == '0));
                        chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end else begin
                    chk("result_held", bus.ALUResult, prev_res);
                end
            end
            prev_res = bus.ALUResult;
        end
    end

    logic [3:0] legal_ops [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011,
                                  4'b0100, 4'b1111, 4'b1110};

    initial begin
        int c0;
        reset     = 1'b0;
        bus.start = 1'b0;
        scramble_inputs();
        step(3);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", bus.ALUResult, 32'd0);
        chk("rst_zero", 32'(bus.Zero), 32'd1);
        reset  = 1'b1;
        mon_en = 1'b1;
        step(1);

        // Directed cases from the operation table and boundaries.
        issue(4'b0011, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        wait_idle();
        issue(4'b0100, 32'h1234_5678, 32'h1234_5678, 0);
        wait_idle();
        issue(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        wait_idle();
        issue(4'b1111, 32'h0000_0001, 32'h0000_0001, 31);
        wait_idle();
        issue(4'b1110, 32'h0, 32'h8000_0000, 4);
        wait_idle();
        issue(4'b1110, 32'h0, 32'hDEAD_BEEF, 0);
        wait_idle();
        issue(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
        wait_idle();

        // start during a shift is ignored.
        issue(4'b1111, 32'h0, 32'h1357_9BDF, 10);
        step(2);
        bus.start        = 1'b1;
        bus.ALUOperation = 4'b0011;
        step(1);
        bus.start = 1'b0;
        wait_idle();

        // start held into the DONE cycle is ignored.
        issue(4'b0001, 32'h0F0F_0000, 32'h0000_F0F0, 0);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        wait_idle();

        // Randomized mix, including undefined codes.
        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 15));
            else op = legal_ops[$urandom_range(0, 6)];
            issue(op, $urandom, $urandom, int'($urandom_range(0, 31)));
            wait_idle();
        end

        // Reset in cycle 6 of a 20-bit shift aborts it with no done pulse.
        issue(4'b1111, 32'h0, 32'h0000_00FF, 20);
        c0 = cyc - 1;
        while (cyc < c0 + 6) step(1);
        reset = 1'b0;
        sb.delete();
        win_hi = 0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_result", bus.ALUResult, 32'd0);
        chk("abort_zero", 32'(bus.Zero), 32'd1);
        step(2);
        reset = 1'b1;
        step(40);

        // Ops still work after the abort.
        issue(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
        wait_idle();
        step(2);
        chk("queue_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
